// File: rtl/sine_lut_arbiter.sv
// sine_lut_arbiter: shares one quarter-wave sine lookup among voices, round-robin or fixed-priority when SINE_ARB_FIXED_PRIO_EN is defined
module sine_lut_arbiter #(
  parameter int NUM_VOICES = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clk_en,
  input  logic [NUM_VOICES-1:0]           i_req,
  input  logic [16*NUM_VOICES-1:0]        i_phase,
  output logic [NUM_VOICES-1:0]           o_grant,
  output logic [15:0]                     o_phase,
  input  logic signed [15:0]              i_sine,
  output logic signed [15:0]              o_val,
  output logic                            o_valid,
  output logic [$clog2(NUM_VOICES)-1:0]   o_voice,
  output logic                            o_idle
);
  localparam int VW = $clog2(NUM_VOICES);
  logic [VW-1:0] base, pick, idx;
  logic found, issue;
  logic [PIPE_LAT:0] tag_v;
  logic [PIPE_LAT:0][VW-1:0] tag_id;
`ifdef SINE_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [VW-1:0] ptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (issue) ptr <= pick + VW'(1);
  assign base = ptr;
`endif
  // power-of-two voice count lets the search index wrap by plain overflow
  always_comb begin
    pick = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      idx = base + VW'(i);
      if (!found && i_req[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  assign issue = clk_en & ~rst & found;
  assign o_grant = issue ? NUM_VOICES'(1) << pick : '0;
  assign o_idle = ~|tag_v;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_phase <= '0;
      tag_v <= '0;
      tag_id <= '0;
      o_val <= '0;
      o_voice <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= clk_en & tag_v[PIPE_LAT];
      if (clk_en) begin
        tag_v <= {tag_v[PIPE_LAT-1:0], issue};
        tag_id <= {tag_id[PIPE_LAT-1:0], pick};
        if (issue) o_phase <= i_phase[16*pick +: 16];
        if (tag_v[PIPE_LAT]) begin
          o_val <= i_sine;
          o_voice <= tag_id[PIPE_LAT];
        end
      end
    end
endmodule

// File: tb/tb_sine_lut_arbiter.sv
// tb_sine_lut_arbiter: directed bench for sine_lut_arbiter with a scoreboard model of issued lookups
module tb_sine_lut_arbiter;
  localparam int N = 4, PL = 3;
  logic clk = 0, rst = 1, clk_en = 1;
  logic [N-1:0] i_req = '0;
  logic [16*N-1:0] i_phase = '0;
  logic [N-1:0] o_grant;
  logic [15:0] o_phase, o_val, i_sine;
  logic o_valid, o_idle;
  logic [1:0] o_voice;
  logic [PL-1:0][15:0] stub = '0;
  int compared = 0, mismatched = 0;

  sine_lut_arbiter #(.NUM_VOICES(N), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_req(i_req), .i_phase(i_phase),
    .o_grant(o_grant), .o_phase(o_phase), .i_sine(i_sine), .o_val(o_val),
    .o_valid(o_valid), .o_voice(o_voice), .o_idle(o_idle));

  always #5 clk = ~clk;
  always @(posedge clk) if (clk_en) stub <= {stub[PL-2:0], o_phase};
  assign i_sine = stub[PL-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_voice(input logic [N-1:0] req, input int ptr);
    int start;
`ifdef SINE_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < N; k++) if (req[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  typedef struct { int due; int voice; logic [15:0] ph; } item_t;
  item_t pend[$];
  int m_ptr = 0, m_edge = 0, m_voice = 0;
  logic m_valid = 0;
  logic [15:0] m_val = 0, m_phase = 0;

  // each lookup is due PL+1 enabled edges after it issues, carrying the issued phase
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      pend.delete();
      m_ptr = 0; m_valid = 0; m_val = 0; m_voice = 0; m_phase = 0;
    end else if (!clk_en) m_valid = 0;
    else begin
      int g;
      m_edge++;
      m_valid = 0;
      if (pend.size() > 0 && pend[0].due == m_edge) begin
        m_valid = 1; m_voice = pend[0].voice; m_val = pend[0].ph;
        void'(pend.pop_front());
      end
      g = pick_voice(i_req, m_ptr);
      if (g >= 0) begin
        pend.push_back('{m_edge + PL + 1, g, i_phase[16*g +: 16]});
        m_ptr = (g + 1) % N;
        m_phase = i_phase[16*g +: 16];
      end
    end
  end

  initial forever begin
    int g;
    logic [N-1:0] eg;
    @(negedge clk);
    g = pick_voice(i_req, m_ptr);
    eg = '0;
    if (clk_en && !rst && g >= 0) eg[g] = 1'b1;
    chk("grant", o_grant, eg);
    chk("phase", o_phase, m_phase);
    chk("valid", o_valid, m_valid);
    chk("val", o_val, m_val);
    chk("voice", o_voice, m_voice);
    chk("idle", o_idle, pend.size() == 0);
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_rst();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    int seen;
    logic [N-1:0] tbl [6];
    step(2);
    chk("rst_idle", o_idle, 1);
    chk("rst_phase", o_phase, 0);
    chk("rst_valid", o_valid, 0);
    rst = 0;
    i_phase[32 +: 16] = 16'h1234;
    i_req = 4'b0100;
    #1 chk("t31_grant", o_grant, 4'b0100);
    step();
    i_req = '0;
    chk("t31_busy", o_idle, 0);
    step(3);
    chk("t31_wait", o_valid, 0);
    step();
    chk("t31_valid", o_valid, 1);
    chk("t31_val", o_val, 16'h1234);
    chk("t31_voice", o_voice, 2);
    chk("t31_idle", o_idle, 1);
    step();
    chk("t31_pulse", o_valid, 0);
    chk("t31_hold", o_val, 16'h1234);
    pulse_rst();
    i_phase = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
    i_req = 4'hF;
    for (int k = 0; k < 12; k++) begin
`ifndef SINE_ARB_FIXED_PRIO_EN
      #1 chk("t32_grant", o_grant, 4'b0001 << (k % 4));
`endif
      step();
`ifndef SINE_ARB_FIXED_PRIO_EN
      if (k >= 4) begin
        chk("t32_valid", o_valid, 1);
        chk("t32_val", o_val, 16'h1000 * (k % 4 + 1));
      end
`endif
    end
    i_req = '0;
    step(5);
    i_req = 4'b0010;
    step();
    i_req = 4'b1010;
`ifndef SINE_ARB_FIXED_PRIO_EN
    #1 chk("t33_g3", o_grant, 4'b1000);
    step();
    #1 chk("t33_g1", o_grant, 4'b0010);
    step();
    #1 chk("t33_g3b", o_grant, 4'b1000);
    step();
`else
    step(3);
`endif
    i_req = '0;
    step(5);
`ifdef SINE_ARB_FIXED_PRIO_EN
    i_req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t36_grant", o_grant, 4'b0001);
      step();
    end
    i_req = '0;
    step(5);
`endif
    i_phase[0 +: 16] = 16'h0ABC;
    i_req = 4'b0001;
    step();
    i_req = '0;
    for (int j = 0; j < 4; j++) begin
      clk_en = 0;
      step();
      chk("t34_off", o_valid, 0);
      clk_en = 1;
      step();
      chk("t34_on", o_valid, j == 3);
    end
    chk("t34_val", o_val, 16'h0ABC);
    chk("t34_voice", o_voice, 0);
    clk_en = 0;
    i_req = 4'b0001;
    #1 chk("t34_gate", o_grant, 0);
    step();
    i_req = '0;
    chk("t34_frozen_valid", o_valid, 0);
    chk("t34_frozen_val", o_val, 16'h0ABC);
    clk_en = 1;
    step();
    i_phase[16 +: 16] = 16'h5555;
    i_req = 4'b0010;
    step();
    i_req = '0;
    step(2);
    rst = 1;
    #1;
    chk("t35_valid", o_valid, 0);
    chk("t35_idle", o_idle, 1);
    chk("t35_phase", o_phase, 0);
    chk("t35_val", o_val, 0);
    chk("t35_voice", o_voice, 0);
    step();
    rst = 0;
    seen = 0;
    repeat (6) begin
      step();
      if (o_valid) seen++;
    end
    chk("t35_novalid", seen, 0);
    tbl = '{4'b0110, 4'b1001, 4'b1111, 4'b0000, 4'b1000, 4'b0101};
    for (int k = 0; k < 6; k++) begin
      i_phase = {$urandom, $urandom};
      i_req = tbl[k];
      step();
    end
    i_req = '0;
    step(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
